// File: rtl/mstr_collector.sv
// mstr_collector
//   Collects beats from an upstream master into a small buffer, counts the
//   beats of each frame and lets a downstream reader pop the buffered words.
//   The frame ends on mstr_cmplt. The controller then waits for the buffer to
//   drain, pulses frame_done for one cycle and returns to idle.
//
// Parameters
//   DW    data word width (even). Defaults to `DATA_WIDTH, which is 32.
//   DEPTH buffer depth in words (power of two, >= 2)
//   CNT_W width of the accepted-beat counter (saturating)
//
// Ports
//   clk, rst           clock and synchronous active-high reset
//   mstr_data          upstream data word
//   mstr_data_valid    00 none, 01 low half valid, 11 both halves, 10 illegal
//   mstr_cmplt         frame-complete marker
//   mstr_ready         collector accepts a beat this cycle
//   rd_en              downstream pop request
//   rd_data, rd_vld    popped word and its stored valid code (latency 1)
//   fifo_empty/full    buffer occupancy flags
//   word_cnt           beats accepted in the current frame
//   frame_done         one-cycle pulse at frame end
//   proto_err          sticky flag, set by valid code 10
//   checksum           only when COLLECTOR_CHECKSUM_EN is defined: XOR of the
//                      frame's beats, with the high half masked for code 01
`ifndef DATA_WIDTH
`define DATA_WIDTH 32
`endif

module mstr_collector #(
  parameter int DW    = `DATA_WIDTH,
  parameter int DEPTH = 8,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [DW-1:0]    mstr_data,
  input  logic [1:0]       mstr_data_valid,
  input  logic             mstr_cmplt,
  output logic             mstr_ready,
  input  logic             rd_en,
  output logic [DW-1:0]    rd_data,
  output logic [1:0]       rd_vld,
  output logic             fifo_empty,
  output logic             fifo_full,
  output logic [CNT_W-1:0] word_cnt,
  output logic             frame_done,
  output logic             proto_err
`ifdef COLLECTOR_CHECKSUM_EN
  ,
  output logic [DW-1:0]    checksum
`endif
);

  localparam int AW = $clog2(DEPTH);
  localparam int HW = DW / 2;

  typedef enum logic [1:0] {IDLE, RECV, DRAIN, DONE} state_t;

  state_t state_reg, state_next;

  logic [DW+1:0] mem [DEPTH];
  logic [AW-1:0] wr_ptr_reg, rd_ptr_reg;
  logic [AW:0]   count_reg;
  logic [DW+1:0] rd_word_reg;
  logic [CNT_W-1:0] word_cnt_reg;
  logic          proto_err_reg;

  logic beat_ok;
  logic push;
  logic pop;

  assign fifo_empty = (count_reg == '0);
  assign fifo_full  = (count_reg == (AW+1)'(DEPTH));

  // Codes 01 and 11 are the only legal beat qualifiers.
  assign beat_ok = (mstr_data_valid == 2'b01) || (mstr_data_valid == 2'b11);
  assign push    = beat_ok && mstr_ready;
  assign pop     = rd_en && !fifo_empty;

  // State register
  always_ff @(posedge clk) begin
    if (rst) state_reg <= IDLE;
    else     state_reg <= state_next;
  end

  // Next-state logic. A beat that arrives together with mstr_cmplt is still
  // pushed, because push depends only on mstr_ready.
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE: begin
        if (mstr_cmplt)  state_next = DRAIN;
        else if (push)   state_next = RECV;
      end
      RECV:  if (mstr_cmplt) state_next = DRAIN;
      DRAIN: if (fifo_empty) state_next = DONE;
      DONE:  state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Output decode of the registered state
  always_comb begin
    mstr_ready = 1'b0;
    frame_done = 1'b0;
    case (state_reg)
      IDLE:  mstr_ready = 1'b1;
      RECV:  mstr_ready = !fifo_full;
      DONE:  frame_done = 1'b1;
      default: ;
    endcase
  end

  // Buffer storage. The array holds no reset so that it maps onto block RAM.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr_reg] <= {mstr_data_valid, mstr_data};
  end

  // Pointers and occupancy. DEPTH is a power of two, so the pointers wrap
  // naturally.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_reg  <= '0;
      rd_ptr_reg  <= '0;
      count_reg   <= '0;
      rd_word_reg <= '0;
    end else begin
      if (push) wr_ptr_reg <= wr_ptr_reg + 1'b1;
      if (pop) begin
        rd_ptr_reg  <= rd_ptr_reg + 1'b1;
        rd_word_reg <= mem[rd_ptr_reg];
      end
      case ({push, pop})
        2'b10:   count_reg <= count_reg + 1'b1;
        2'b01:   count_reg <= count_reg - 1'b1;
        default: count_reg <= count_reg;
      endcase
    end
  end

  assign rd_data = rd_word_reg[DW-1:0];
  assign rd_vld  = rd_word_reg[DW+1:DW];

  // Beat counter. No beat can arrive in DONE, so clearing there loses nothing.
  always_ff @(posedge clk) begin
    if (rst)
      word_cnt_reg <= '0;
    else if (state_reg == DONE)
      word_cnt_reg <= '0;
    else if (push && (word_cnt_reg != {CNT_W{1'b1}}))
      word_cnt_reg <= word_cnt_reg + 1'b1;
  end

  assign word_cnt = word_cnt_reg;

  // Sticky protocol error. Code 10 is flagged whenever it is presented.
  always_ff @(posedge clk) begin
    if (rst)
      proto_err_reg <= 1'b0;
    else if (mstr_data_valid == 2'b10)
      proto_err_reg <= 1'b1;
  end

  assign proto_err = proto_err_reg;

`ifdef COLLECTOR_CHECKSUM_EN
  logic [DW-1:0] checksum_reg;
  logic [DW-1:0] beat_masked;

  // A low-half-only beat contributes zeros in its upper half.
  assign beat_masked = (mstr_data_valid == 2'b01) ?
                       {{HW{1'b0}}, mstr_data[HW-1:0]} : mstr_data;

  always_ff @(posedge clk) begin
    if (rst)
      checksum_reg <= '0;
    else if (state_reg == DONE)
      checksum_reg <= '0;
    else if (push)
      checksum_reg <= checksum_reg ^ beat_masked;
  end

  assign checksum = checksum_reg;
`endif

endmodule

// File: tb/tb_mstr_collector.sv
// Self-checking bench for mstr_collector. It drives a per-cycle vector table
// for a normal frame, an empty frame and an illegal code. Hand-written
// sequences then cover buffer full, simultaneous push and pop, reset
// mid-frame and counter saturation.
`timescale 1ns/1ps

module tb_mstr_collector;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] mstr_data;
  logic [1:0]  mstr_data_valid;
  logic        mstr_cmplt;
  logic        mstr_ready;
  logic        rd_en;
  logic [31:0] rd_data;
  logic [1:0]  rd_vld;
  logic        fifo_empty;
  logic        fifo_full;
  logic [3:0]  word_cnt;
  logic        frame_done;
  logic        proto_err;
`ifdef COLLECTOR_CHECKSUM_EN
  logic [31:0] checksum;
`endif

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  mstr_collector #(.DW(32), .DEPTH(8), .CNT_W(4)) dut (
    .clk(clk),
    .rst(rst),
    .mstr_data(mstr_data),
    .mstr_data_valid(mstr_data_valid),
    .mstr_cmplt(mstr_cmplt),
    .mstr_ready(mstr_ready),
    .rd_en(rd_en),
    .rd_data(rd_data),
    .rd_vld(rd_vld),
    .fifo_empty(fifo_empty),
    .fifo_full(fifo_full),
    .word_cnt(word_cnt),
    .frame_done(frame_done),
    .proto_err(proto_err)
`ifdef COLLECTOR_CHECKSUM_EN
    ,
    .checksum(checksum)
`endif
  );

  typedef struct {
    logic        rst;
    logic [31:0] d;
    logic [1:0]  v;
    logic        c;
    logic        re;
    logic        rdy;
    logic        emp;
    logic        full;
    logic [31:0] rdd;
    logic [1:0]  rv;
    logic [3:0]  cnt;
    logic        fd;
    logic        pe;
    logic [31:0] cks;
  } vec_t;

  vec_t vecs [13];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Apply one cycle of inputs. Outputs are sampled 1 ns after the edge.
  task automatic step(input logic r, input logic [31:0] d, input logic [1:0] v,
                      input logic c, input logic re);
    rst = r; mstr_data = d; mstr_data_valid = v; mstr_cmplt = c; rd_en = re;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    step(1'b1, 32'h0, 2'b00, 1'b0, 1'b0);
  endtask

  initial begin
    rst = 1'b1; mstr_data = '0; mstr_data_valid = '0; mstr_cmplt = 1'b0; rd_en = 1'b0;

    // Fields: rst, d, v, c, re, rdy, emp, full, rdd, rv, cnt, fd, pe, cks
    vecs[0]  = '{1'b1, 32'h0,        2'b00, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 32'h0,        2'b00, 4'd0, 1'b0, 1'b0, 32'h0};
    vecs[1]  = '{1'b0, 32'h11111111, 2'b11, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 32'h0,        2'b00, 4'd1, 1'b0, 1'b0, 32'h11111111};
    vecs[2]  = '{1'b0, 32'h22222222, 2'b11, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 32'h11111111, 2'b11, 4'd2, 1'b0, 1'b0, 32'h33333333};
    vecs[3]  = '{1'b0, 32'h00003333, 2'b01, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 32'h22222222, 2'b11, 4'd3, 1'b0, 1'b0, 32'h33330000};
    vecs[4]  = '{1'b0, 32'h0,        2'b00, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 32'h00003333, 2'b01, 4'd3, 1'b0, 1'b0, 32'h33330000};
    vecs[5]  = '{1'b0, 32'h0,        2'b00, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 32'h00003333, 2'b01, 4'd3, 1'b1, 1'b0, 32'h33330000};
    vecs[6]  = '{1'b0, 32'h0,        2'b00, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 32'h00003333, 2'b01, 4'd0, 1'b0, 1'b0, 32'h0};
    vecs[7]  = '{1'b0, 32'h0,        2'b00, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 32'h00003333, 2'b01, 4'd0, 1'b0, 1'b0, 32'h0};
    vecs[8]  = '{1'b0, 32'h0,        2'b00, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 32'h00003333, 2'b01, 4'd0, 1'b1, 1'b0, 32'h0};
    vecs[9]  = '{1'b0, 32'h0,        2'b00, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 32'h00003333, 2'b01, 4'd0, 1'b0, 1'b0, 32'h0};
    vecs[10] = '{1'b0, 32'hDEADBEEF, 2'b10, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 32'h00003333, 2'b01, 4'd0, 1'b0, 1'b1, 32'h0};
    vecs[11] = '{1'b0, 32'h0,        2'b00, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 32'h00003333, 2'b01, 4'd0, 1'b0, 1'b1, 32'h0};
    vecs[12] = '{1'b1, 32'h0,        2'b00, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 32'h0,        2'b00, 4'd0, 1'b0, 1'b0, 32'h0};

    @(negedge clk);
    for (int i = 0; i < 13; i++) begin
      step(vecs[i].rst, vecs[i].d, vecs[i].v, vecs[i].c, vecs[i].re);
      $display("vec %0d: rdy=%0b emp=%0b full=%0b rd=%h/%0b cnt=%0d fd=%0b pe=%0b",
               i, mstr_ready, fifo_empty, fifo_full, rd_data, rd_vld, word_cnt, frame_done, proto_err);
      chk($sformatf("v%0d mstr_ready", i), 32'(mstr_ready), 32'(vecs[i].rdy));
      chk($sformatf("v%0d fifo_empty", i), 32'(fifo_empty), 32'(vecs[i].emp));
      chk($sformatf("v%0d fifo_full", i),  32'(fifo_full),  32'(vecs[i].full));
      chk($sformatf("v%0d rd_data", i),    rd_data,         vecs[i].rdd);
      chk($sformatf("v%0d rd_vld", i),     32'(rd_vld),     32'(vecs[i].rv));
      chk($sformatf("v%0d word_cnt", i),   32'(word_cnt),   32'(vecs[i].cnt));
      chk($sformatf("v%0d frame_done", i), 32'(frame_done), 32'(vecs[i].fd));
      chk($sformatf("v%0d proto_err", i),  32'(proto_err),  32'(vecs[i].pe));
`ifdef COLLECTOR_CHECKSUM_EN
      chk($sformatf("v%0d checksum", i),   checksum,        vecs[i].cks);
`endif
    end

    // Fill to full with no reads, then pop one to make room for beat 9.
    do_reset();
    for (int i = 0; i < 8; i++) step(1'b0, 32'(i + 1), 2'b11, 1'b0, 1'b0);
    $display("fill: rdy=%0b full=%0b cnt=%0d", mstr_ready, fifo_full, word_cnt);
    chk("fill full", 32'(fifo_full), 32'd1);
    chk("fill ready", 32'(mstr_ready), 32'd0);
    chk("fill cnt", 32'(word_cnt), 32'd8);
    step(1'b0, 32'd9, 2'b11, 1'b0, 1'b0);
    $display("refused beat 9: cnt=%0d", word_cnt);
    chk("refused cnt", 32'(word_cnt), 32'd8);
    step(1'b0, 32'd9, 2'b11, 1'b0, 1'b1);
    $display("pop while full: rd=%h rdy=%0b full=%0b", rd_data, mstr_ready, fifo_full);
    chk("pop rd_data", rd_data, 32'd1);
    chk("pop full", 32'(fifo_full), 32'd0);
    chk("pop ready", 32'(mstr_ready), 32'd1);
    chk("pop cnt", 32'(word_cnt), 32'd8);
    step(1'b0, 32'd9, 2'b11, 1'b0, 1'b0);
    $display("beat 9 accepted: cnt=%0d full=%0b", word_cnt, fifo_full);
    chk("beat9 cnt", 32'(word_cnt), 32'd9);
    chk("beat9 full", 32'(fifo_full), 32'd1);
    for (int i = 0; i < 8; i++) begin
      step(1'b0, 32'h0, 2'b00, 1'b0, 1'b1);
      $display("drain %0d: rd=%h", i, rd_data);
      chk($sformatf("drain%0d rd_data", i), rd_data, 32'(i + 2));
    end
    chk("drain empty", 32'(fifo_empty), 32'd1);
    step(1'b0, 32'h0, 2'b00, 1'b1, 1'b0);
    step(1'b0, 32'h0, 2'b00, 1'b0, 1'b0);
    $display("fill frame end: fd=%0b cnt=%0d", frame_done, word_cnt);
    chk("fill frame_done", 32'(frame_done), 32'd1);
    chk("fill frame cnt", 32'(word_cnt), 32'd9);
    step(1'b0, 32'h0, 2'b00, 1'b0, 1'b0);
    chk("fill fd drop", 32'(frame_done), 32'd0);
    chk("fill cnt clear", 32'(word_cnt), 32'd0);

    // Four words buffered, then push and pop in the same cycle.
    do_reset();
    for (int i = 0; i < 4; i++) step(1'b0, 32'hA0 + 32'(i), 2'b11, 1'b0, 1'b0);
    step(1'b0, 32'hA4, 2'b11, 1'b0, 1'b1);
    $display("push+pop: rd=%h emp=%0b full=%0b cnt=%0d", rd_data, fifo_empty, fifo_full, word_cnt);
    chk("pp rd_data", rd_data, 32'hA0);
    chk("pp full", 32'(fifo_full), 32'd0);
    chk("pp cnt", 32'(word_cnt), 32'd5);
    for (int i = 1; i <= 4; i++) begin
      step(1'b0, 32'h0, 2'b00, 1'b0, 1'b1);
      $display("pp drain %0d: rd=%h", i, rd_data);
      chk($sformatf("pp drain%0d", i), rd_data, 32'hA0 + 32'(i));
    end
    chk("pp empty", 32'(fifo_empty), 32'd1);
    step(1'b0, 32'h0, 2'b00, 1'b0, 1'b1);
    $display("pop on empty: rd=%h", rd_data);
    chk("empty pop hold", rd_data, 32'hA4);

    // Reset in RECV with five words buffered.
    do_reset();
    for (int i = 0; i < 5; i++) step(1'b0, 32'hC0 + 32'(i), 2'b11, 1'b0, 1'b0);
    chk("r6 cnt before", 32'(word_cnt), 32'd5);
    do_reset();
    $display("reset mid-frame: emp=%0b cnt=%0d rdy=%0b", fifo_empty, word_cnt, mstr_ready);
    chk("r6 empty", 32'(fifo_empty), 32'd1);
    chk("r6 cnt", 32'(word_cnt), 32'd0);
    chk("r6 ready", 32'(mstr_ready), 32'd1);
    step(1'b0, 32'h0, 2'b00, 1'b0, 1'b1);
    chk("r6 rd ignored", rd_data, 32'h0);
    step(1'b0, 32'h0, 2'b00, 1'b1, 1'b0);
    chk("r6 drain ready", 32'(mstr_ready), 32'd0);
    step(1'b0, 32'h0, 2'b00, 1'b0, 1'b0);
    $display("r6 empty frame: fd=%0b cnt=%0d", frame_done, word_cnt);
    chk("r6 frame_done", 32'(frame_done), 32'd1);

    // Saturation: 20 beats through a 4-bit counter, read concurrently.
    do_reset();
    for (int i = 0; i < 20; i++) step(1'b0, 32'(i), 2'b11, 1'b0, 1'b1);
    $display("saturate: cnt=%0d rd=%h", word_cnt, rd_data);
    chk("sat cnt", 32'(word_cnt), 32'd15);
    chk("sat rd_data", rd_data, 32'd18);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/mstr_collector.md
MSTR_COLLECTOR -- requirements
Module: mstr_collector

Interface
REQ-001 Parameter DW, default 32: data word width; even, equals `DATA_WIDTH.
REQ-002 Parameter DEPTH, default 8: buffer depth in words; power of two, at least 2.
REQ-003 Parameter CNT_W, default 16: width of the accepted-beat counter.
REQ-004 clk  in  1: single clock; all logic on its rising edge.
REQ-005 rst  in  1: reset, synchronous and active-high.
REQ-006 mstr_data  in  DW: master output data from the upstream processing stage.
REQ-007 mstr_data_valid  in  2: beat qualifier: 00 none, 01 low half valid, 11 both halves valid, 10 illegal.
REQ-008 mstr_cmplt  in  1: frame-complete marker from upstream.
REQ-009 mstr_ready  out  1: collector can accept a beat this cycle.
REQ-010 rd_en  in  1: downstream read request.
REQ-011 rd_data  out  DW: word read from the buffer.
REQ-012 rd_vld  out  2: stored valid pattern of rd_data.
REQ-013 fifo_empty / fifo_full  out  1 each: buffer occupancy flags.
REQ-014 word_cnt  out  CNT_W: beats accepted in the current frame.
REQ-015 frame_done  out  1: one-cycle pulse at frame end.
REQ-016 proto_err  out  1: sticky flag for an illegal valid code.

Function
REQ-017 States SHALL be IDLE, RECV, DRAIN, DONE.
REQ-018 A beat transfers when mstr_data_valid is 01 or 11 and mstr_ready=1; data and valid code are written to the buffer.
REQ-019 mstr_ready SHALL be 1 in IDLE, 1 in RECV when not fifo_full, and 0 otherwise; it is a combinational decode of registered state.
REQ-020 IDLE->RECV on the first transferred beat.
REQ-021 RECV->DRAIN when mstr_cmplt=1; a beat presented in the same cycle SHALL be accepted first.
REQ-022 mstr_cmplt=1 in IDLE SHALL go directly to DRAIN, producing an empty frame.
REQ-023 DRAIN->DONE when fifo_empty=1.
REQ-024 DONE SHALL assert frame_done for exactly one cycle, then go to IDLE with word_cnt cleared.
REQ-025 rd_en with buffer not empty SHALL pop one word; rd_data/rd_vld update on the next clock edge (latency 1) and hold otherwise.
REQ-026 rd_en while empty SHALL be ignored with no pointer change.
REQ-027 Simultaneous push and pop SHALL leave occupancy unchanged; pointers wrap modulo DEPTH.
REQ-028 A push when full cannot occur, because mstr_ready=0.
REQ-029 Valid code 10 SHALL be dropped, not counted, and SHALL set proto_err until reset.
REQ-030 word_cnt SHALL increment per transferred beat and saturate at 2^CNT_W-1.

Reset
REQ-031 When rst=1 at a clock edge: state=IDLE, pointers/occupancy=0, rd_data=0, rd_vld=00, word_cnt=0, frame_done=0, proto_err=0, checksum=0.
REQ-032 Reset during any state SHALL abandon the frame; buffered words are discarded.
REQ-033 Reset outputs: fifo_empty=1, fifo_full=0, mstr_ready=1.

Configuration
REQ-034 Macro COLLECTOR_CHECKSUM_EN defined: adds output checksum (DW), the XOR of all transferred beats in the frame with the high half masked to 0 for code 01, and cleared on leaving DONE.
REQ-035 When defined, checksum SHALL be valid and stable while frame_done=1.
REQ-036 When COLLECTOR_CHECKSUM_EN is undefined, the checksum port and its logic SHALL be absent.

Verification
REQ-037 Scenario 1: 3 beats 0x11111111/11, 0x22222222/11, 0x00003333/01, then cmplt, rd_en held high -> reads return the same words and codes in order; frame_done pulses once; word_cnt=3; checksum=0x33330000 if enabled.
REQ-038 Scenario 2: 10 beats with rd_en=0 at DEPTH=8 -> mstr_ready falls after beat 8, fifo_full=1; pop one -> ready=1 the next cycle, beat 9 accepted.
REQ-039 Scenario 3: buffer at 4 words, push and pop in the same cycle -> occupancy stays 4; the pop returns the oldest word.
REQ-040 Scenario 4: valid code 10 with 0xDEADBEEF -> not stored, word_cnt unchanged, proto_err=1 until rst.
REQ-041 Scenario 5: cmplt in IDLE -> DRAIN->DONE, frame_done pulse, word_cnt=0.
REQ-042 Scenario 6: rst asserted in RECV with 5 words buffered -> next cycle fifo_empty=1, word_cnt=0, state IDLE.
